// File: rtl/taint_shift_reg.sv
// Shift register with per-stage taint labels, a saturating fill counter and a sticky control taint.
// Each stage's taint also absorbs the EN and RST_N labels, because those decide every edge.
module taint_shift_reg #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TW    = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [TW-1:0]    RST_N_t,
  input  logic             EN,
  input  logic [TW-1:0]    EN_t,
  input  logic [WIDTH-1:0] D,
  input  logic [TW-1:0]    D_t,
  output logic [WIDTH-1:0] Q,
  output logic [TW-1:0]    Q_t,
  output logic             FULL,
  output logic [TW-1:0]    FULL_t
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] s_q, s_d;
  logic [DEPTH-1:0][TW-1:0]    t_q, t_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        full_q, full_d;
  logic [TW-1:0]               full_t_q, full_t_d;
  logic [TW-1:0]               ctl_t;

  // Next state for a non-reset edge: shift on EN, otherwise hold data while taint still accumulates.
  always_comb begin
    ctl_t    = EN_t | RST_N_t;
    s_d      = s_q;
    t_d      = t_q;
    cnt_d    = cnt_q;
    full_t_d = full_t_q | ctl_t;
    if (EN) begin
      s_d[0] = D;
      t_d[0] = D_t | ctl_t;
      for (int k = 1; k < int'(DEPTH); k++) begin
        s_d[k] = s_q[k-1];
        t_d[k] = t_q[k-1] | ctl_t;
      end
      if (cnt_q != CW'(DEPTH)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        t_d[k] = t_q[k] | ctl_t;
      end
    end
    full_d = (cnt_d == CW'(DEPTH));
  end

  // Reset wins over any shift; it seeds every taint register with the reset label.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s_q      <= '0;
      t_q      <= {DEPTH{RST_N_t}};
      cnt_q    <= '0;
      full_q   <= 1'b0;
      full_t_q <= RST_N_t;
    end else begin
      s_q      <= s_d;
      t_q      <= t_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      full_t_q <= full_t_d;
    end
  end

  assign Q      = s_q[DEPTH-1];
  assign Q_t    = t_q[DEPTH-1];
  assign FULL   = full_q;
  assign FULL_t = full_t_q;

endmodule

// File: tb/tb_taint_shift_reg.sv
// Directed bench for taint_shift_reg: a history-based model checked every cycle plus literal checkpoints.
module tb_taint_shift_reg;
  localparam int unsigned WIDTH = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TW    = 32;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic [TW-1:0]    RST_N_t = '0;
  logic             EN = 1'b0;
  logic [TW-1:0]    EN_t = '0;
  logic [WIDTH-1:0] D = '0;
  logic [TW-1:0]    D_t = '0;
  logic [WIDTH-1:0] Q;
  logic [TW-1:0]    Q_t;
  logic             FULL;
  logic [TW-1:0]    FULL_t;

  int checks = 0;
  int errors = 0;

  taint_shift_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TW(TW)) dut (
    .CLK(CLK), .RST_N(RST_N), .RST_N_t(RST_N_t), .EN(EN), .EN_t(EN_t),
    .D(D), .D_t(D_t), .Q(Q), .Q_t(Q_t), .FULL(FULL), .FULL_t(FULL_t)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: every enabled sample since reset, plus the control label seen at every non-reset edge.
  typedef struct {
    logic [WIDTH-1:0] d;
    logic [TW-1:0]    t;
    int               e;
  } sample_t;

  sample_t       samples[$];
  logic [TW-1:0] ctl_hist[$];
  logic [TW-1:0] rst_t;
  bit            mvalid = 0;

  always @(posedge CLK) begin
    if (!RST_N) begin
      samples.delete();
      ctl_hist.delete();
      rst_t  = RST_N_t;
      mvalid = 1;
    end else if (mvalid) begin
      ctl_hist.push_back(EN_t | RST_N_t);
      if (EN) samples.push_back('{d: D, t: D_t, e: ctl_hist.size() - 1});
    end
  end

  // The word at the output is the sample pushed DEPTH enabled edges ago; its label is its own
  // taint plus every control label from its entry edge on.  Before that it is the reset word.
  always @(negedge CLK) begin
    if (mvalid) begin
      logic [WIDTH-1:0] eq;
      logic [TW-1:0]    et, all_t;
      int               n;
      n = samples.size();
      all_t = rst_t;
      foreach (ctl_hist[i]) all_t |= ctl_hist[i];
      if (n >= int'(DEPTH)) begin
        eq = samples[n - DEPTH].d;
        et = samples[n - DEPTH].t;
        for (int e = samples[n - DEPTH].e; e < ctl_hist.size(); e++) et |= ctl_hist[e];
      end else begin
        eq = '0;
        et = all_t;
      end
      chk("model_Q", 64'(Q), 64'(eq));
      chk("model_Q_t", 64'(Q_t), 64'(et));
      chk("model_FULL", 64'(FULL), 64'(n >= int'(DEPTH)));
      chk("model_FULL_t", 64'(FULL_t), 64'(all_t));
    end
  end

  task automatic tick(input logic rst, input logic [TW-1:0] rt, input logic en,
                      input logic [TW-1:0] et, input logic [WIDTH-1:0] d, input logic [TW-1:0] dt);
    RST_N = rst; RST_N_t = rt; EN = en; EN_t = et; D = d; D_t = dt;
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] fill [4];
    fill[0] = 2'b01; fill[1] = 2'b10; fill[2] = 2'b11; fill[3] = 2'b00;

    // Reset and plain fill
    tick(1'b0, '0, 1'b0, '0, '0, '0);
    chk("rst_Q", 64'(Q), 64'd0);
    chk("rst_FULL", 64'(FULL), 64'd0);
    chk("rst_Q_t", 64'(Q_t), 64'd0);
    chk("rst_FULL_t", 64'(FULL_t), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, '0, 1'b1, '0, fill[i], '0);
      if (i == 2) chk("fill3_FULL", 64'(FULL), 64'd0);
    end
    chk("fill_Q", 64'(Q), 64'd1);
    chk("fill_FULL", 64'(FULL), 64'd1);
    chk("fill_Q_t", 64'(Q_t), 64'd0);

    // Hold with toggling D
    for (int i = 0; i < 5; i++) tick(1'b1, '0, 1'b0, '0, WIDTH'(i), '0);
    chk("hold_Q", 64'(Q), 64'd1);
    chk("hold_FULL", 64'(FULL), 64'd1);
    chk("hold_Q_t", 64'(Q_t), 64'd0);

    // Reset low between edges only: no effect
    RST_N = 1'b0;
    #2 RST_N = 1'b1;
    tick(1'b1, '0, 1'b0, '0, '0, '0);
    chk("glitch_Q", 64'(Q), 64'd1);
    chk("glitch_FULL", 64'(FULL), 64'd1);

    // Data taint travels with its sample
    tick(1'b0, '0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, '0, 1'b1, '0, fill[i], (i == 0) ? 32'h1 : 32'h0);
      if (i == 2) chk("dtaint_early_Q_t", 64'(Q_t), 64'd0);
    end
    chk("dtaint_Q_t", 64'(Q_t), 64'h1);
    chk("dtaint_Q", 64'(Q), 64'd1);
    chk("dtaint_FULL_t", 64'(FULL_t), 64'd0);

    // Enable taint on a hold edge marks every stage
    tick(1'b0, '0, 1'b0, '0, '0, '0);
    tick(1'b1, '0, 1'b0, 32'h100, '0, '0);
    chk("etaint_Q_t", 64'(Q_t), 64'h100);
    chk("etaint_FULL_t", 64'(FULL_t), 64'h100);
    tick(1'b1, '0, 1'b1, '0, 2'b10, '0);
    tick(1'b1, '0, 1'b1, '0, 2'b01, '0);
    chk("etaint_keep_Q_t", 64'(Q_t), 64'h100);
    chk("etaint_keep_FULL_t", 64'(FULL_t), 64'h100);

    // Reset overrides a shift mid-fill
    tick(1'b0, '0, 1'b0, '0, '0, '0);
    tick(1'b1, '0, 1'b1, '0, 2'b10, '0);
    tick(1'b1, '0, 1'b1, '0, 2'b01, '0);
    tick(1'b0, 32'h8000_0000, 1'b1, '0, 2'b11, '0);
    chk("midrst_Q", 64'(Q), 64'd0);
    chk("midrst_FULL", 64'(FULL), 64'd0);
    chk("midrst_Q_t", 64'(Q_t), 64'h8000_0000);
    chk("midrst_FULL_t", 64'(FULL_t), 64'h8000_0000);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, '0, 1'b1, '0, fill[i], '0);
      if (i == 2) chk("refill3_FULL", 64'(FULL), 64'd0);
    end
    chk("refill_FULL", 64'(FULL), 64'd1);
    chk("refill_Q", 64'(Q), 64'd1);
    chk("refill_Q_t", 64'(Q_t), 64'd0);
    chk("refill_FULL_t", 64'(FULL_t), 64'h8000_0000);

    // Saturation: ten enabled edges, D = edge number
    tick(1'b0, '0, 1'b0, '0, '0, '0);
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1, '0, 1'b1, '0, WIDTH'(i), '0);
      if (i >= 4) chk("sat_FULL", 64'(FULL), 64'd1);
    end
    chk("sat_Q", 64'(Q), 64'd3);

    // Mixed traffic against the model
    for (int i = 0; i < 40; i++) begin
      tick(($urandom_range(0, 9) != 0), 32'(1) << $urandom_range(0, 31), 1'($urandom),
           ($urandom_range(0, 3) == 0) ? 32'(1) << $urandom_range(0, 31) : 32'h0,
           WIDTH'($urandom), ($urandom_range(0, 2) == 0) ? $urandom : 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
